aes_inv_mix_column_seq: RTL and testbench

Iterative AES InvMixColumns unit for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock cycle, using the GF(2^8) matrix rows {0e,0b,0d,09} rotated. It returns the result over a second valid/ready handshake. It is the inverse of the existing combinational aes_mix_column and trades 4 cycles of latency for one quarter of the column logic.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_inv_mix_single_column.sv | 20 ++
 rtl/aes_inv_mix_column_seq.sv | 91 +++++++++
 tb/tb_aes_inv_mix_column_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the InvMixColumns FSM encoding.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [0:15][7:0] aes_state_t;
    typedef logic [0:3][7:0]  aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } inv_mc_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add product; with a constant b it folds to a small XOR tree.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_mix_single_column.sv
// InvMixColumns on one 32-bit column, rows {0e,0b,0d,09} rotated.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module aes_inv_mix_single_column
    import aes_pkg::*;
(
    input  aes_col_t data,
    output aes_col_t result
);

    assign result[0] = gf_mul(data[0], 8'h0e) ^ gf_mul(data[1], 8'h0b)
                     ^ gf_mul(data[2], 8'h0d) ^ gf_mul(data[3], 8'h09);
    assign result[1] = gf_mul(data[0], 8'h09) ^ gf_mul(data[1], 8'h0e)
                     ^ gf_mul(data[2], 8'h0b) ^ gf_mul(data[3], 8'h0d);
    assign result[2] = gf_mul(data[0], 8'h0d) ^ gf_mul(data[1], 8'h09)
                     ^ gf_mul(data[2], 8'h0e) ^ gf_mul(data[3], 8'h0b);
    assign result[3] = gf_mul(data[0], 8'h0b) ^ gf_mul(data[1], 8'h0d)
                     ^ gf_mul(data[2], 8'h09) ^ gf_mul(data[3], 8'h0e);

endmodule

// File: rtl/aes_inv_mix_column_seq.sv
// Iterative InvMixColumns: one column per cycle through a single shared column unit.
// Latency: 4 cycles from accept edge to valid_o; one block per 5 cycles sustained.
// Backpressure: result held in DONE until ready_i; ready_o low while busy.
module aes_inv_mix_column_seq
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    output logic       ready_o,
    input  aes_state_t state_i,
    output logic       valid_o,
    input  logic       ready_i,
    output aes_state_t state_o,
    output logic       busy_o
);

    inv_mc_state_e fsm_q;
    aes_state_t    state_q;
    aes_state_t    state_upd;
    logic [1:0]    col_q;
    aes_col_t      col_sel;
    aes_col_t      col_res;

    always_comb begin
        col_sel = state_q[0:3];
        case (col_q)
            2'd1:    col_sel = state_q[4:7];
            2'd2:    col_sel = state_q[8:11];
            2'd3:    col_sel = state_q[12:15];
            default: col_sel = state_q[0:3];
        endcase
    end

    aes_inv_mix_single_column u_col (
        .data   (col_sel),
        .result (col_res)
    );

    always_comb begin
        state_upd = state_q;
        case (col_q)
            2'd1:    state_upd[4:7]   = col_res;
            2'd2:    state_upd[8:11]  = col_res;
            2'd3:    state_upd[12:15] = col_res;
            default: state_upd[0:3]   = col_res;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            col_q   <= 2'd0;
            state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (valid_i) begin
                        state_q <= state_i;
                        col_q   <= 2'd0;
                        fsm_q   <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= state_upd;
                    col_q   <= col_q + 2'd1;
                    if (col_q == 2'd3) fsm_q <= DONE;
                end
                DONE: begin
                    // Output handshake and next accept share this edge.
                    if (ready_i) begin
                        if (valid_i) begin
                            state_q <= state_i;
                            col_q   <= 2'd0;
                            fsm_q   <= BUSY;
                        end else begin
                            fsm_q   <= IDLE;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (fsm_q == IDLE) || ((fsm_q == DONE) && ready_i);
    assign valid_o = (fsm_q == DONE);
    assign busy_o  = (fsm_q == BUSY);
    assign state_o = state_q;

endmodule

// File: tb/tb_aes_inv_mix_column_seq.sv
// Directed and round-trip bench for aes_inv_mix_column_seq.
module tb_aes_inv_mix_column_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] state_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] state_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int n_acc    = 0;
    int n_out    = 0;

    localparam logic [127:0] V1  = 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6;
    localparam logic [127:0] E1  = 128'hdb135345_f20a225c_2d26314c_d4d4d4d5;
    localparam logic [127:0] VC6 = {16{8'hc6}};
    localparam logic [127:0] V01 = {16{8'h01}};

    aes_inv_mix_column_seq dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .state_i (state_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .state_o (state_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle++;
        if (rst_n) begin
            if (valid_i && ready_o) n_acc++;
            if (valid_o && ready_i) n_out++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns, rows {02,03,01,01} rotated.
    function automatic logic [127:0] mix_state(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int k = 0; k < 4; k++)
                r[127 - 8*(4*c + k) -: 8] = xt(a[k]) ^ xt(a[(k+1)%4]) ^ a[(k+1)%4]
                                          ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
        return r;
    endfunction

    // Entered at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [127:0] s);
        int n;
        valid_i = 1'b1;
        state_i = s;
        n = 0;
        #1;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", {127'd0, ready_o}, 128'd1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (!valid_o && cyc < 30) begin
            if (busy_o) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 30) chk("valid_timeout", {127'd0, valid_o}, 128'd1);
    endtask

    initial begin
        int cyc, nb, t_a, got, n, acc0, out0;
        logic [127:0] orig, held;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        state_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {127'd0, valid_o}, 128'd0);
        chk("rst_busy",  {127'd0, busy_o},  128'd0);
        chk("rst_ready", {127'd0, ready_o}, 128'd1);
        chk("rst_state", state_o, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single block, ready_i high.
        ready_i = 1'b1;
        send(V1);
        wait_valid(cyc, nb);
        chk("single_latency", cyc, 4);
        chk("single_busy_cycles", nb, 4);
        chk("single_result", state_o, E1);
        @(negedge clk);
        chk("single_drained", {127'd0, valid_o}, 128'd0);
        chk("single_idle_ready", {127'd0, ready_o}, 128'd1);

        // Fixed points.
        send(VC6);
        wait_valid(cyc, nb);
        chk("fixed_c6", state_o, VC6);
        @(negedge clk);
        send(V01);
        wait_valid(cyc, nb);
        chk("fixed_01", state_o, V01);
        @(negedge clk);

        // Backpressure: hold the result for 10 cycles.
        ready_i = 1'b0;
        send(V1);
        wait_valid(cyc, nb);
        held = state_o;
        chk("bp_result", held, E1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {127'd0, valid_o}, 128'd1);
            chk("bp_state_held", state_o, E1);
            chk("bp_ready_low",  {127'd0, ready_o}, 128'd0);
        end
        out0 = n_out;
        ready_i = 1'b1;
        #1;
        chk("bp_ready_pass", {127'd0, ready_o}, 128'd1);
        @(negedge clk);
        chk("bp_released", {127'd0, valid_o}, 128'd0);
        repeat (2) @(negedge clk);
        chk("bp_one_transfer", n_out - out0, 1);

        // Back-to-back with valid_i held high.
        valid_i = 1'b1;
        state_i = V1;
        @(negedge clk);
        state_i = VC6;
        wait_valid(cyc, nb);
        t_a = cycle;
        chk("b2b_first", state_o, E1);
        #1;
        chk("b2b_done_ready", {127'd0, ready_o}, 128'd1);
        @(negedge clk);
        chk("b2b_second_accepted", {127'd0, busy_o}, 128'd1);
        valid_i = 1'b0;
        wait_valid(cyc, nb);
        chk("b2b_spacing", cycle - t_a, 5);
        chk("b2b_second", state_o, VC6);
        @(negedge clk);

        // Asynchronous reset two cycles into BUSY.
        send(V1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {127'd0, valid_o}, 128'd0);
        chk("arst_busy",  {127'd0, busy_o},  128'd0);
        chk("arst_ready", {127'd0, ready_o}, 128'd1);
        chk("arst_state", state_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_no_stale_valid", {127'd0, valid_o}, 128'd0);
        end
        send(V01);
        wait_valid(cyc, nb);
        chk("arst_latency", cyc, 4);
        chk("arst_result", state_o, V01);
        @(negedge clk);

        // Round trip through forward MixColumns with random gaps and backpressure.
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(mix_state(orig));
            got = 0;
            n = 0;
            while (!got && n < 40) begin
                ready_i = 1'($urandom_range(0, 1));
                if (valid_o && ready_i) begin
                    chk("roundtrip", state_o, orig);
                    got = 1;
                end
                @(negedge clk);
                n++;
            end
            chk("roundtrip_done", got, 1);
        end
        repeat (2) @(negedge clk);
        chk("rt_accepts", n_acc - acc0, 1000);
        chk("rt_outputs", n_out - out0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
